// File: rtl/adma_controller.sv
// ADMA2-style descriptor engine: walks a descriptor table in system memory and
// moves 64-bit words between memory and the SD data FIFO.
module adma_controller #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STOP,
  input  logic              command_reg_write,
  input  logic              command_reg_continue,
  input  logic              direction,
  input  logic [ADDR_W-1:0] starting_address,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wdata,
  input  logic              fifo_full,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_empty,
  output logic [1:0]        adma_state,
  output logic              dma_int,
  output logic              xfer_done,
  output logic              adma_error,
  output logic [1:0]        adma_err_state
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_FDS  = 2'd1,
    ST_CADR = 2'd2,
    ST_TFR  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] L_WORD = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] L_DESC = ADDR_W'(16);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_desc_ptr, r_xfer_addr, r_word1;
  logic [DATA_W-1:0] r_word0;
  logic [13:0]       r_count;
  logic              r_dir, r_fds_beat, r_hold, r_int, r_end;
  logic              r_wr_d, r_cont_d, r_start_q, r_cont_q;
  logic              r_error, r_dma_int, r_xfer_done;
  logic [1:0]        r_err_state;

  logic              w_req, w_beat, w_can_issue, w_bad, w_last;
  logic [1:0]        w_act;
  logic [13:0]       w_len_words;

  assign w_act       = r_word0[5:4];
  assign w_bad       = ~r_word0[0] | (w_act == 2'b01);
  // Length field in 8-byte words; a zero field encodes the full 64 KiB.
  assign w_len_words = (r_word0[31:19] == 13'd0) ? 14'd8192 : {1'b0, r_word0[31:19]};
  assign w_last      = (r_count == 14'd1);
  assign w_can_issue = r_dir ? ~fifo_full : ~fifo_empty;
  assign w_req       = (r_state == ST_FDS) | ((r_state == ST_TFR) & (r_hold | w_can_issue));
  assign w_beat      = w_req & mem_ack & ~STOP;

  assign adma_state     = r_state;
  assign dma_int        = r_dma_int;
  assign xfer_done      = r_xfer_done;
  assign adma_error     = r_error;
  assign adma_err_state = r_err_state;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_STOP;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (STOP) begin
      w_next = ST_STOP;
    end else begin
      case (r_state)
        ST_STOP: begin
          if (r_start_q | (r_cont_q & r_error)) w_next = ST_FDS;
          else                                  w_next = ST_STOP;
        end
        ST_FDS: begin
          if (w_beat & r_fds_beat) w_next = ST_CADR;
          else                     w_next = ST_FDS;
        end
        ST_CADR: begin
          if (w_bad)                  w_next = ST_STOP;
          else if (w_act == 2'b10)    w_next = ST_TFR;
          else if (r_word0[1])        w_next = ST_STOP;
          else                        w_next = ST_FDS;
        end
        ST_TFR: begin
          if (w_beat & w_last) w_next = r_end ? ST_STOP : ST_FDS;
          else                 w_next = ST_TFR;
        end
        default: w_next = ST_STOP;
      endcase
    end
  end

  always_comb begin
    mem_req    = w_req;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fifo_wr_en = 1'b0;
    fifo_wdata = '0;
    fifo_rd_en = 1'b0;
    case (r_state)
      ST_FDS: mem_addr = r_fds_beat ? (r_desc_ptr + L_WORD) : r_desc_ptr;
      ST_TFR: begin
        mem_we     = ~r_dir;
        mem_addr   = r_xfer_addr;
        mem_wdata  = r_dir ? '0 : fifo_rdata;
        fifo_wr_en = r_dir & w_beat;
        fifo_wdata = (r_dir & w_beat) ? mem_rdata : '0;
        fifo_rd_en = ~r_dir & w_beat;
      end
      default: mem_addr = '0;
    endcase
  end

  // Datapath: strobe edge detection, descriptor capture, transfer counters and pulses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_desc_ptr  <= '0;
      r_xfer_addr <= '0;
      r_word0     <= '0;
      r_word1     <= '0;
      r_count     <= 14'd0;
      r_dir       <= 1'b0;
      r_fds_beat  <= 1'b0;
      r_hold      <= 1'b0;
      r_int       <= 1'b0;
      r_end       <= 1'b0;
      r_wr_d      <= 1'b0;
      r_cont_d    <= 1'b0;
      r_start_q   <= 1'b0;
      r_cont_q    <= 1'b0;
      r_error     <= 1'b0;
      r_err_state <= 2'd0;
      r_dma_int   <= 1'b0;
      r_xfer_done <= 1'b0;
    end else begin
      r_wr_d      <= command_reg_write;
      r_cont_d    <= command_reg_continue;
      r_start_q   <= command_reg_write & ~r_wr_d;
      r_cont_q    <= command_reg_continue & ~r_cont_d;
      r_dma_int   <= 1'b0;
      r_xfer_done <= 1'b0;
      if (STOP) begin
        r_hold     <= 1'b0;
        r_fds_beat <= 1'b0;
      end else begin
        case (r_state)
          ST_STOP: begin
            r_fds_beat <= 1'b0;
            r_hold     <= 1'b0;
            if (r_start_q) begin
              r_desc_ptr <= starting_address;
              r_dir      <= direction;
              r_error    <= 1'b0;
            end else if (r_cont_q & r_error) begin
              r_error <= 1'b0;
            end
          end
          ST_FDS: begin
            if (w_beat) begin
              r_fds_beat <= ~r_fds_beat;
              if (r_fds_beat) r_word1 <= mem_rdata[ADDR_W-1:0];
              else            r_word0 <= mem_rdata;
            end
          end
          ST_CADR: begin
            if (w_bad) begin
              r_error     <= 1'b1;
              r_err_state <= ST_FDS;
            end else if (w_act == 2'b10) begin
              r_xfer_addr <= r_word1;
              r_count     <= w_len_words;
              r_desc_ptr  <= r_desc_ptr + L_DESC;
              r_int       <= r_word0[2];
              r_end       <= r_word0[1];
            end else begin
              r_desc_ptr  <= (w_act == 2'b11) ? r_word1 : (r_desc_ptr + L_DESC);
              r_dma_int   <= r_word0[2];
              r_xfer_done <= r_word0[1];
            end
          end
          ST_TFR: begin
            // Once issued, a beat is held until acked regardless of FIFO flags.
            r_hold <= w_req & ~mem_ack;
            if (w_beat) begin
              r_xfer_addr <= r_xfer_addr + L_WORD;
              r_count     <= r_count - 14'd1;
              if (w_last) begin
                r_dma_int   <= r_int;
                r_xfer_done <= r_end;
              end
            end
          end
          default: r_hold <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adma_controller.sv
// Directed bench for adma_controller: table-driven memory model, FIFO model and
// activity logger, with hand-computed expectations checked by immediate assertions.
module tb_adma_controller;
  logic        CLK = 1'b0;
  logic        RESET, STOP, command_reg_write, command_reg_continue, direction;
  logic [63:0] starting_address;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        fifo_wr_en, fifo_full, fifo_rd_en, fifo_empty;
  logic [63:0] fifo_wdata, fifo_rdata;
  logic [1:0]  adma_state, adma_err_state;
  logic        dma_int, xfer_done, adma_error;

  int errors = 0;
  int checks = 0;

  logic [63:0] tbl_a [0:15];
  logic [63:0] tbl_d [0:15];
  logic [63:0] src_mem [0:7];
  int          src_cnt = 0;
  int          ack_delay = 0;
  logic        log_clr = 1'b0;

  int          wcnt = 0, src_idx = 0;
  int          rd_cnt = 0, wr_cnt = 0, push_cnt = 0, pop_cnt = 0, int_cnt = 0, done_cnt = 0;
  int          stab_viol = 0, launch_viol = 0;
  logic [63:0] rd_addr [0:15];
  logic [63:0] wr_addr [0:15];
  logic [63:0] wr_data [0:15];
  logic [63:0] push_data [0:15];
  logic [63:0] last_rd = 64'd0;
  logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_stop = 1'b0;
  logic [63:0] p_addr = 64'd0, p_wdata = 64'd0;

  adma_controller dut (
    .CLK(CLK), .RESET(RESET), .STOP(STOP),
    .command_reg_write(command_reg_write), .command_reg_continue(command_reg_continue),
    .direction(direction), .starting_address(starting_address),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .adma_state(adma_state), .dma_int(dma_int), .xfer_done(xfer_done),
    .adma_error(adma_error), .adma_err_state(adma_err_state)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] pat(input logic [63:0] a);
    return {32'hCAFEF00D, a[31:0]};
  endfunction

  // Memory: descriptor table entries, otherwise an address-derived data pattern.
  always_comb begin
    mem_rdata = pat(mem_addr);
    for (int k = 0; k < 16; k++)
      if (tbl_a[k] == mem_addr) mem_rdata = tbl_d[k];
  end
  assign mem_ack    = mem_req && (wcnt >= ack_delay);
  assign fifo_empty = (src_idx >= src_cnt);
  assign fifo_rdata = src_mem[src_idx[2:0]];

  // Logger: records beats, FIFO traffic, pulses and handshake-rule violations.
  always @(posedge CLK) begin
    if (log_clr) begin
      rd_cnt = 0; wr_cnt = 0; push_cnt = 0; pop_cnt = 0; int_cnt = 0; done_cnt = 0;
      stab_viol = 0; launch_viol = 0; src_idx = 0;
    end else begin
      if (mem_req && mem_ack && !STOP) begin
        if (mem_we) begin
          if (wr_cnt < 16) begin wr_addr[wr_cnt] = mem_addr; wr_data[wr_cnt] = mem_wdata; end
          wr_cnt++;
        end else begin
          if (rd_cnt < 16) rd_addr[rd_cnt] = mem_addr;
          rd_cnt++;
          last_rd = mem_addr;
        end
      end
      if (fifo_wr_en) begin
        if (push_cnt < 16) push_data[push_cnt] = fifo_wdata;
        push_cnt++;
      end
      if (fifo_rd_en) begin pop_cnt++; src_idx++; end
      if (dma_int) int_cnt++;
      if (xfer_done) done_cnt++;
      if (p_req && !p_ack && !p_stop &&
          !(mem_req && mem_addr == p_addr && mem_we == p_we && mem_wdata == p_wdata))
        stab_viol++;
      if (adma_state == 2'd3 && !mem_we && mem_req && !(p_req && !p_ack) && fifo_full)
        launch_viol++;
    end
    if (mem_req && !mem_ack) wcnt++;
    else                     wcnt = 0;
    p_req = mem_req; p_ack = mem_ack; p_we = mem_we; p_stop = STOP;
    p_addr = mem_addr; p_wdata = mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_logs();
    log_clr = 1'b1;
    @(negedge CLK);
    log_clr = 1'b0;
  endtask

  task automatic kick(input logic [63:0] base, input logic dir);
    starting_address  = base;
    direction         = dir;
    command_reg_write = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_idle(input int hold, input int budget, input bit toggle, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge CLK);
      if (i >= hold) begin command_reg_write = 1'b0; command_reg_continue = 1'b0; end
      if (toggle) fifo_full = ~fifo_full;
      if (adma_state == 2'd0 && !mem_req) done = 1'b1;
    end
    fifo_full = 1'b0;
    chk(tag, 64'(done), 64'd1);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1; STOP = 1'b0; command_reg_write = 1'b0; command_reg_continue = 1'b0;
    direction = 1'b0; starting_address = 64'd0; fifo_full = 1'b0;
    for (int k = 0; k < 16; k++) begin tbl_a[k] = 64'hFFFF_FFFF_FFFF_FFF0; tbl_d[k] = 64'd0; end
    for (int k = 0; k < 8; k++) src_mem[k] = 64'd0;
    tbl_a[0]  = 64'h0;   tbl_d[0]  = 64'h0000_0000_0020_0023; // valid end tran 32 B
    tbl_a[1]  = 64'h8;   tbl_d[1]  = 64'h1000;
    tbl_a[2]  = 64'h200; tbl_d[2]  = 64'h0000_0000_0010_0025; // valid int tran 16 B
    tbl_a[3]  = 64'h208; tbl_d[3]  = 64'h2000;
    tbl_a[4]  = 64'h210; tbl_d[4]  = 64'h0000_0000_0000_0031; // valid link
    tbl_a[5]  = 64'h218; tbl_d[5]  = 64'h100;
    tbl_a[6]  = 64'h100; tbl_d[6]  = 64'h0000_0000_0008_0023; // valid end tran 8 B
    tbl_a[7]  = 64'h108; tbl_d[7]  = 64'h3000;
    tbl_a[8]  = 64'h40;  tbl_d[8]  = 64'h0000_0000_0008_0022; // not valid
    tbl_a[9]  = 64'h48;  tbl_d[9]  = 64'h4000;
    tbl_a[10] = 64'h80;  tbl_d[10] = 64'h0000_0000_0000_0023; // length 0 -> 64 KiB
    tbl_a[11] = 64'h88;  tbl_d[11] = 64'h10000;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    clr_logs();

    chk("rst_state", 64'(adma_state), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_err", 64'(adma_error), 64'd0);
    chk("rst_pulses", 64'({dma_int, xfer_done, fifo_wr_en, fifo_rd_en}), 64'd0);

    // Single descriptor, memory -> FIFO, zero-wait.
    starting_address = 64'h0; direction = 1'b1; command_reg_write = 1'b1;
    @(negedge CLK);
    chk("lat_req_n", 64'(mem_req), 64'd0);
    @(negedge CLK);
    chk("lat_req_n1", 64'({mem_req, mem_we}), 64'b10);
    chk("lat_addr", mem_addr, 64'h0);
    wait_idle(0, 50, 1'b0, "t1_timeout");
    chk("t1_rd_cnt", 64'(rd_cnt), 64'd6);
    chk("t1_rd1", rd_addr[1], 64'h8);
    chk("t1_rd2", rd_addr[2], 64'h1000);
    chk("t1_rd5", rd_addr[5], 64'h1018);
    chk("t1_push_cnt", 64'(push_cnt), 64'd4);
    chk("t1_push0", push_data[0], 64'hCAFEF00D_00001000);
    chk("t1_push3", push_data[3], 64'hCAFEF00D_00001018);
    chk("t1_done", 64'(done_cnt), 64'd1);
    chk("t1_int", 64'(int_cnt), 64'd0);
    chk("t1_state", 64'(adma_state), 64'd0);

    // Continue edge without pending error is ignored.
    clr_logs();
    command_reg_continue = 1'b1;
    repeat (2) @(negedge CLK);
    command_reg_continue = 1'b0;
    repeat (4) @(negedge CLK);
    chk("cont_ign_state", 64'(adma_state), 64'd0);
    chk("cont_ign_rd", 64'(rd_cnt), 64'd0);

    // Chain tran -> link -> tran, FIFO -> memory.
    clr_logs();
    src_mem[0] = 64'hA1A1_0000_0000_0001;
    src_mem[1] = 64'hA2A2_0000_0000_0002;
    src_mem[2] = 64'hA3A3_0000_0000_0003;
    src_cnt = 3;
    kick(64'h200, 1'b0);
    wait_idle(0, 80, 1'b0, "t2_timeout");
    chk("t2_wr_cnt", 64'(wr_cnt), 64'd3);
    chk("t2_wa0", wr_addr[0], 64'h2000);
    chk("t2_wd0", wr_data[0], 64'hA1A1_0000_0000_0001);
    chk("t2_wa1", wr_addr[1], 64'h2008);
    chk("t2_wd1", wr_data[1], 64'hA2A2_0000_0000_0002);
    chk("t2_wa2", wr_addr[2], 64'h3000);
    chk("t2_wd2", wr_data[2], 64'hA3A3_0000_0000_0003);
    chk("t2_pops", 64'(pop_cnt), 64'd3);
    chk("t2_int", 64'(int_cnt), 64'd1);
    chk("t2_done", 64'(done_cnt), 64'd1);
    src_cnt = 0;

    // Invalid descriptor, then fix and continue.
    clr_logs();
    kick(64'h40, 1'b1);
    wait_idle(0, 50, 1'b0, "t3_timeout");
    chk("t3_err", 64'(adma_error), 64'd1);
    chk("t3_err_state", 64'(adma_err_state), 64'd1);
    chk("t3_rd_cnt", 64'(rd_cnt), 64'd2);
    chk("t3_push", 64'(push_cnt), 64'd0);
    chk("t3_done", 64'(done_cnt), 64'd0);
    tbl_d[8] = 64'h0000_0000_0008_0023;
    clr_logs();
    command_reg_continue = 1'b1;
    repeat (2) @(negedge CLK);
    wait_idle(0, 50, 1'b0, "t3c_timeout");
    chk("t3c_err", 64'(adma_error), 64'd0);
    chk("t3c_rd0", rd_addr[0], 64'h40);
    chk("t3c_rd2", rd_addr[2], 64'h4000);
    chk("t3c_push", 64'(push_cnt), 64'd1);
    chk("t3c_done", 64'(done_cnt), 64'd1);

    // Backpressure: fifo_full toggling, 3 wait states.
    clr_logs();
    ack_delay = 3;
    kick(64'h0, 1'b1);
    wait_idle(0, 200, 1'b1, "t4_timeout");
    chk("t4_push_cnt", 64'(push_cnt), 64'd4);
    chk("t4_push0", push_data[0], 64'hCAFEF00D_00001000);
    chk("t4_push3", push_data[3], 64'hCAFEF00D_00001018);
    chk("t4_stable", 64'(stab_viol), 64'd0);
    chk("t4_launch_full", 64'(launch_viol), 64'd0);
    chk("t4_done", 64'(done_cnt), 64'd1);

    // STOP while beat 2 of 4 is outstanding.
    clr_logs();
    ack_delay = 2;
    kick(64'h0, 1'b1);
    command_reg_write = 1'b0;
    for (int i = 0; i < 200 && push_cnt < 1; i++) @(negedge CLK);
    chk("t5_first_push", 64'(push_cnt), 64'd1);
    STOP = 1'b1;
    @(negedge CLK);
    chk("t5_req_low", 64'(mem_req), 64'd0);
    chk("t5_state", 64'(adma_state), 64'd0);
    @(negedge CLK);
    STOP = 1'b0;
    repeat (10) @(negedge CLK);
    chk("t5_push_cnt", 64'(push_cnt), 64'd1);
    chk("t5_done", 64'(done_cnt), 64'd0);
    chk("t5_err", 64'(adma_error), 64'd0);
    chk("t5_stable", 64'(stab_viol), 64'd0);

    // Start held 100 cycles, length 0 -> 8192 beats, single run.
    clr_logs();
    ack_delay = 0;
    kick(64'h80, 1'b1);
    wait_idle(98, 9000, 1'b0, "t6_timeout");
    chk("t6_push_cnt", 64'(push_cnt), 64'd8192);
    chk("t6_rd_cnt", 64'(rd_cnt), 64'd8194);
    chk("t6_last_rd", last_rd, 64'h1FFF8);
    chk("t6_done", 64'(done_cnt), 64'd1);
    repeat (20) @(negedge CLK);
    chk("t6_no_rerun", 64'(rd_cnt), 64'd8194);
    chk("t6_state", 64'(adma_state), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adma_controller.md
# adma_controller

ADMA2-style descriptor engine for the SD host data path. It consumes the command-register strobes (`command_reg_write`, `command_reg_continue`, `STOP`), `direction` and `starting_address`, then walks a descriptor table in system memory. It moves 64-bit words between system memory and the data FIFO, and reports completion, interrupts and errors back to the host register block.

## Interface
- `ADDR_W`, 64, system-memory byte-address width
- `DATA_W`, 64, memory/FIFO word width (fixed 64; the parameter exists for documentation only)
- `CLK` in 1: single clock, rising edge
- `RESET` in 1: synchronous, active-high
- `STOP` in 1: abort; level-sensitive
- `command_reg_write` in 1: start; acts on the 0->1 edge only
- `command_reg_continue` in 1: resume after error; acts on the 0->1 edge only
- `direction` in 1: 1 = memory->FIFO (card write), 0 = FIFO->memory; sampled at start
- `starting_address` in 64: descriptor table base (byte address); sampled at start
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 64, `mem_wdata` out 64: memory request
- `mem_ack` in 1, `mem_rdata` in 64: memory response
- `fifo_wr_en` out 1, `fifo_wdata` out 64, `fifo_full` in 1: FIFO push side
- `fifo_rd_en` out 1, `fifo_rdata` in 64, `fifo_empty` in 1: FIFO pop side (first-word-fallthrough)
- `adma_state` out 2: 0 STOP, 1 FDS, 2 CADR, 3 TFR
- `dma_int` out 1, `xfer_done` out 1: one-cycle pulses
- `adma_error` out 1: sticky; `adma_err_state` out 2: state in which the error occurred

## Operation
- **Descriptor format.** Each descriptor is two 64-bit words at pointer P and P+8.
  - Word0: [0] Valid, [1] End, [2] Int, [5:4] Act (00 nop, 01 reserved, 10 tran, 11 link), [31:16] length in bytes. Bits [2:0] of length are ignored; length 0 means 65536 bytes.
  - Word1: [63:0] address.
- **ST_STOP.**
  - A start edge loads desc_ptr = `starting_address` and latches `direction`, clears `adma_error`, then moves to FDS.
  - A continue edge with `adma_error`=1 clears `adma_error` and moves to FDS, keeping desc_ptr (re-fetches the failing descriptor).
  - A continue edge while no error is pending is ignored.
- **FDS.** Two read beats (word0, then word1) go out back-to-back. Then move to CADR.
- **CADR** (one cycle).
  - If Valid=0 or Act=01: set `adma_error`, set `adma_err_state`=FDS, go to STOP.
  - tran: load xfer address and word count = length/8, set desc_ptr += 16, go to TFR.
  - nop: desc_ptr += 16.
  - link: desc_ptr = word1 address.
  - For nop/link: if End, go to STOP with a `xfer_done` pulse; else go to FDS. Pulse `dma_int` if Int.
- **TFR.**
  - direction=1: raise `mem_req` (read) only while `fifo_full`=0. On ack, `fifo_wr_en`=1 with `fifo_wdata`=`mem_rdata` in the same cycle.
  - direction=0: raise `mem_req` (write) only while `fifo_empty`=0, with `mem_wdata`=`fifo_rdata`. On ack, `fifo_rd_en`=1 (pop).
  - Each ack: xfer address += 8, count -= 1.
  - Count reaches 0: pulse `dma_int` if Int. If End, pulse `xfer_done` and go to STOP; else go to FDS.
- **STOP input.** From any state, go to STOP at the next edge.
  - `mem_req` drops the same edge; an in-flight beat is abandoned (no FIFO push/pop).
  - No `xfer_done` and no error are reported.
  - STOP has priority over ack, start and continue.
- **Arithmetic.** Address arithmetic is 64-bit modulo 2^64; wrap is silent. Word count is 14 bits (max 8192).

## Timing
- **Reset values.** Every output is 0 after RESET (`adma_state`=STOP). desc_ptr and counters are cleared.
- **Start latency.** Start edge sampled at edge N; `mem_req`=1 with `mem_addr`=`starting_address`, `mem_we`=0 after edge N+1.
- **Memory handshake.** `mem_req`/`mem_addr`/`mem_we`/`mem_wdata` stay stable until the cycle where `mem_req`&`mem_ack`=1; that cycle completes the beat. `mem_req` may stay high for the next beat with new address the following cycle. `mem_ack` without `mem_req` is ignored.
- **Back-to-back throughput.** With zero wait states, FDS takes 2 cycles, CADR 1 cycle, TFR 1 beat per cycle.
- **Pulse timing.** `xfer_done`/`dma_int` are high for exactly one cycle, registered, in the cycle after the final ack or after CADR.
- **Simultaneous start and continue edges.** Start wins.
- **RESET mid-operation.** Behaves as RESET from idle; no pulses are produced.

## Test plan
- Single descriptor {Valid, End, tran, length 32, address 0x1000} at base 0x0, direction=1, zero-wait memory -> reads at 0x0, 0x8, then 0x1000..0x1018; 4 FIFO pushes; `xfer_done` pulse; `adma_state`=0.
- Chain: tran 16 B @0x2000 (Int) -> link to 0x100 -> tran 8 B @0x3000 (End), direction=0 -> 3 memory writes carrying FIFO data in order; `dma_int` once; `xfer_done` once.
- Descriptor with Valid=0 at 0x40 -> `adma_error`=1, `adma_err_state`=1, no data beats. Fix the descriptor, pulse continue -> re-fetch at 0x40 and complete.
- Backpressure: `fifo_full` toggled every other cycle, `mem_ack` delayed 3 cycles -> no push while full, request signals stable while waiting, exact word count.
- STOP asserted during TFR beat 2 of 4 -> `mem_req` low next cycle, state STOP, no `xfer_done`, no further FIFO activity.
- `command_reg_write` held high for 100 cycles -> exactly one run; length field 0 -> 8192 beats.
